// File: rtl/l2cache_req_arb_np_if.sv
// L2 request channel bundle: NPORTS upstream valid/retry ports plus one arbitrated downstream port.
// Pure wiring, no latency.
// Retry flows opposite to valid on every channel; master = requesters/consumer side, slave = arbiter.
interface l2cache_req_arb_np_if #(
    parameter int NPORTS = 4,
    parameter int REQ_W  = 36
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]       in_req_valid;
    logic [NPORTS-1:0]       in_req_retry;
    logic [NPORTS*REQ_W-1:0] in_req;
    logic                    out_req_valid;
    logic                    out_req_retry;
    logic [REQ_W-1:0]        out_req;
    logic [PW-1:0]           out_req_port;

    modport master (
        output in_req_valid, in_req, out_req_retry,
        input  in_req_retry, out_req_valid, out_req, out_req_port
    );

    modport slave (
        input  in_req_valid, in_req, out_req_retry,
        output in_req_retry, out_req_valid, out_req, out_req_port
    );
endinterface

// File: rtl/l2cache_req_arb_np.sv
// N-port L2 request front end: per-port DEPTH FIFOs, round-robin arbiter, registered output, stats.
// Latency 2 cycles from input accept to out_req_valid; 1 request/cycle when downstream never retries.
// Backpressure: in_req_retry[i] when port FIFO is full (registered); output holds while out_req_retry.
module l2cache_req_arb_np #(
    parameter int NPORTS = 4,
    parameter int REQ_W  = 36,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    l2cache_req_arb_np_if.slave  bus,
    output logic [CNT_W-1:0]     stats_ngrant,
    output logic [CNT_W-1:0]     stats_nstall
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [REQ_W-1:0]  mem [NPORTS][DEPTH];
    logic [AW-1:0]     wr_ptr [NPORTS];
    logic [AW-1:0]     rd_ptr [NPORTS];
    logic [AW:0]       cnt    [NPORTS];
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] cand;

    logic              any;
    logic [PW-1:0]     rr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     idx_p;
    logic              load;

    logic              out_valid;
    logic [REQ_W-1:0]  out_dat;
    logic [PW-1:0]     out_port;

    assign bus.in_req_retry  = full;
    assign bus.out_req_valid = out_valid;
    assign bus.out_req       = out_dat;
    assign bus.out_req_port  = out_port;

    // Output register refills whenever it is empty or being consumed this edge.
    assign load = !out_valid || !bus.out_req_retry;

    // Per-port full/push/pop decode; retry comes from registered count only, so no bypass.
    always_comb begin
        full = '0;
        push = '0;
        pop  = '0;
        cand = '0;
        for (int i = 0; i < NPORTS; i++) begin
            full[i] = (cnt[i] == FULL);
            push[i] = bus.in_req_valid[i] && !full[i];
            cand[i] = (cnt[i] != '0);
            pop[i]  = load && any && (winner == PW'(i));
        end
    end

    // Round-robin scan starting one past the last winner.
    always_comb begin
        any    = 1'b0;
        winner = rr;
        idx_p  = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx_p = PW'((int'(rr) + k) % NPORTS);
            if (!any && cand[idx_p]) begin
                any    = 1'b1;
                winner = idx_p;
            end
        end
    end

    // FIFO storage; contents are don't-care until pointers say otherwise, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.in_req[i*REQ_W +: REQ_W];
            end
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + (AW+1)'(1);
                    2'b01:   cnt[i] <= cnt[i] - (AW+1)'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Output register and RR pointer; payload/port held while stalled or idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
            out_port  <= '0;
            rr        <= PW'(NPORTS - 1);
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_dat  <= mem[winner][rd_ptr[winner]];
                out_port <= winner;
                rr       <= winner;
            end
        end
    end

    // Grant counter wraps; stall counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stats_ngrant <= '0;
            stats_nstall <= '0;
        end else begin
            if (out_valid && !bus.out_req_retry) begin
                stats_ngrant <= stats_ngrant + CNT_W'(1);
            end
            if (out_valid && bus.out_req_retry && (stats_nstall != '1)) begin
                stats_nstall <= stats_nstall + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_l2cache_req_arb_np.sv
// Directed bench for l2cache_req_arb_np: reset, RR order, stall/backpressure, full-FIFO push+pop,
// async mid-stream reset, grant wrap and stall saturation.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_l2cache_req_arb_np;
    localparam int NP = 4;
    localparam int RW = 36;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] stats_ngrant;
    logic [CW-1:0] stats_nstall;

    int n_chk = 0;
    int n_err = 0;

    l2cache_req_arb_np_if #(.NPORTS(NP), .REQ_W(RW)) bus ();

    l2cache_req_arb_np #(
        .NPORTS(NP), .REQ_W(RW), .DEPTH(2), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stats_ngrant (stats_ngrant),
        .stats_nstall (stats_nstall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [RW-1:0] d);
        bus.in_req_valid[p]     = v;
        bus.in_req[p*RW +: RW]  = d;
    endtask

    task automatic idle_inputs();
        bus.in_req_valid  = '0;
        bus.in_req        = '0;
        bus.out_req_retry = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [RW-1:0] pay(input int p);
        return {4'(p), 32'hC0DE_0000};
    endfunction

    initial begin
        int acc;
        int cyc;
        bit seen;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();

        // 1: reset values, then single request latency
        check("rst_valid", 64'(bus.out_req_valid), 64'd0);
        check("rst_req",   64'(bus.out_req), 64'd0);
        check("rst_port",  64'(bus.out_req_port), 64'd0);
        check("rst_retry", 64'(bus.in_req_retry), 64'd0);
        check("rst_ngrant", 64'(stats_ngrant), 64'd0);
        check("rst_nstall", 64'(stats_nstall), 64'd0);
        set_req(0, 1'b1, 36'h0ABCD1234);
        tick();
        set_req(0, 1'b0, '0);
        check("t1_valid_k", 64'(bus.out_req_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus.out_req_valid), 64'd1);
        check("t1_req",   64'(bus.out_req), 64'h0ABCD1234);
        check("t1_port",  64'(bus.out_req_port), 64'd0);
        tick();
        check("t1_ngrant", 64'(stats_ngrant), 64'd1);
        check("t1_empty",  64'(bus.out_req_valid), 64'd0);

        // 2: all ports backlogged, RR order 0,1,2,3,...
        do_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, pay(p));
        tick();
        for (int n = 0; n < 8; n++) begin
            tick();
            check("t2_valid", 64'(bus.out_req_valid), 64'd1);
            check("t2_port",  64'(bus.out_req_port), 64'(n % NP));
            check("t2_req",   64'(bus.out_req), 64'(pay(n % NP)));
        end
        idle_inputs();

        // 3: port2 sends 3 requests into a stalled output
        do_reset();
        bus.out_req_retry = 1'b1;
        set_req(2, 1'b1, 36'h2_0000_000A);
        tick();
        set_req(2, 1'b1, 36'h2_0000_000B);
        tick();
        check("t3_valid", 64'(bus.out_req_valid), 64'd1);
        check("t3_reqA",  64'(bus.out_req), 64'h2_0000_000A);
        check("t3_port",  64'(bus.out_req_port), 64'd2);
        check("t3_retry0", 64'(bus.in_req_retry[2]), 64'd0);
        set_req(2, 1'b1, 36'h2_0000_000C);
        tick();
        set_req(2, 1'b0, '0);
        check("t3_retry1", 64'(bus.in_req_retry[2]), 64'd1);
        check("t3_holdA",  64'(bus.out_req), 64'h2_0000_000A);
        check("t3_nstall1", 64'(stats_nstall), 64'd1);
        tick();
        tick();
        check("t3_holdA2", 64'(bus.out_req), 64'h2_0000_000A);
        check("t3_holdp",  64'(bus.out_req_port), 64'd2);
        check("t3_nstall3", 64'(stats_nstall), 64'd3);
        bus.out_req_retry = 1'b0;
        tick();
        check("t3_reqB",   64'(bus.out_req), 64'h2_0000_000B);
        check("t3_ngrant1", 64'(stats_ngrant), 64'd1);
        check("t3_nstall", 64'(stats_nstall), 64'd3);
        tick();
        check("t3_reqC",   64'(bus.out_req), 64'h2_0000_000C);
        tick();
        check("t3_drained", 64'(bus.out_req_valid), 64'd0);
        check("t3_ngrant3", 64'(stats_ngrant), 64'd3);

        // 4: full FIFO popped while a push is attempted
        do_reset();
        bus.out_req_retry = 1'b1;
        set_req(1, 1'b1, 36'h1_0000_0001);
        tick();
        set_req(1, 1'b1, 36'h1_0000_0002);
        tick();
        set_req(1, 1'b1, 36'h1_0000_0003);
        tick();
        set_req(1, 1'b1, 36'h1_0000_0004);
        bus.out_req_retry = 1'b0;
        check("t4_full",  64'(bus.in_req_retry[1]), 64'd1);
        check("t4_reqX",  64'(bus.out_req), 64'h1_0000_0001);
        tick();
        check("t4_reqY",  64'(bus.out_req), 64'h1_0000_0002);
        check("t4_notfull", 64'(bus.in_req_retry[1]), 64'd0);
        check("t4_ngrant1", 64'(stats_ngrant), 64'd1);
        tick();
        set_req(1, 1'b0, '0);
        check("t4_reqZ",  64'(bus.out_req), 64'h1_0000_0003);
        tick();
        check("t4_reqW",  64'(bus.out_req), 64'h1_0000_0004);
        check("t4_validW", 64'(bus.out_req_valid), 64'd1);
        tick();
        check("t4_nodup", 64'(bus.out_req_valid), 64'd0);
        check("t4_ngrant4", 64'(stats_ngrant), 64'd4);

        // 5: asynchronous reset mid-stream
        do_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, pay(p));
        tick();
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("t5_valid", 64'(bus.out_req_valid), 64'd0);
        check("t5_port",  64'(bus.out_req_port), 64'd0);
        check("t5_req",   64'(bus.out_req), 64'd0);
        check("t5_ngrant", 64'(stats_ngrant), 64'd0);
        check("t5_retry", 64'(bus.in_req_retry), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.out_req_valid) seen = 1'b1;
        end
        check("t5_seen", 64'(seen), 64'd1);
        check("t5_port0", 64'(bus.out_req_port), 64'd0);
        check("t5_req0",  64'(bus.out_req), 64'(pay(0)));
        idle_inputs();

        // 6: 130 transfers wrap the grant counter, long stall saturates the stall counter
        do_reset();
        set_req(0, 1'b1, 36'h0_1234_5678);
        acc = 0;
        cyc = 0;
        while (acc < 130 && cyc < 400) begin
            if (!bus.in_req_retry[0]) acc++;
            tick();
            cyc++;
        end
        set_req(0, 1'b0, '0);
        check("t6_accepts", 64'(acc), 64'd130);
        for (int n = 0; n < 5; n++) tick();
        check("t6_idle",   64'(bus.out_req_valid), 64'd0);
        check("t6_ngrant", 64'(stats_ngrant), 64'd2);
        check("t6_nstall0", 64'(stats_nstall), 64'd0);
        bus.out_req_retry = 1'b1;
        set_req(0, 1'b1, 36'h0_0000_0077);
        tick();
        set_req(0, 1'b0, '0);
        for (int n = 0; n < 200; n++) tick();
        check("t6_nstall_sat", 64'(stats_nstall), 64'd127);
        check("t6_stall_valid", 64'(bus.out_req_valid), 64'd1);
        check("t6_stall_req", 64'(bus.out_req), 64'h0_0000_0077);
        check("t6_ngrant_hold", 64'(stats_ngrant), 64'd2);
        bus.out_req_retry = 1'b0;
        tick();
        check("t6_ngrant3", 64'(stats_ngrant), 64'd3);
        check("t6_nstall_keep", 64'(stats_nstall), 64'd127);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
